// File: rtl/mem_access_monitor.sv
// rtl/mem_access_monitor.sv - bus access monitor with windowed capture log FIFO and halt control
//
// Watches a core's memory bus. While running, every access inside the
// address window is logged (type, address, data) into a small FIFO that a
// consumer drains. The monitor stops on a halt address or after a run-cycle
// limit and then keeps draining until reset.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   enable               starts the run from IDLE
//   address, we          bus address and write strobe from the core
//   wdata, rdata         core write data / memory read data
//   log_ready            consumer accepts the head entry
//   log_valid            FIFO holds at least one entry
//   log_we/addr/data     head entry (zero while empty or in reset)
//   overflow, drop_count sticky drop flag and saturating drop counter
//   halted, halt_cause   HALTED state, cause (1 = halt address, 2 = timeout)
//   cycle_count          saturating count of RUN cycles
module mem_access_monitor #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            DEPTH     = 16,
  parameter logic [AW-1:0] HALT_ADDR = 'hFFC,
  parameter logic [AW-1:0] WIN_MASK  = 'h800,
  parameter logic [AW-1:0] WIN_MATCH = 'h800,
  parameter int            TIMEOUT   = 2000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic [AW-1:0] address,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          log_ready,
  output logic          log_valid,
  output logic          log_we,
  output logic [AW-1:0] log_addr,
  output logic [DW-1:0] log_data,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic          halted,
  output logic [1:0]    halt_cause,
  output logic [31:0]   cycle_count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state;

  logic [DEPTH-1:0] mem_we;
  logic [AW-1:0]    mem_addr [DEPTH];
  logic [DW-1:0]    mem_data [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic is_halt;
  logic in_win;
  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic timeout_hit;

  assign is_halt     = (address == HALT_ADDR);
  assign in_win      = ((address & WIN_MASK) == WIN_MATCH);
  // The halt address itself is never logged even when it lies in the window.
  assign capture     = (state == RUN) && in_win && !is_halt;
  assign full        = (count == FULL_CNT);
  assign log_valid   = (count != '0);
  assign pop         = log_valid && log_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push        = capture && (!full || pop);
  assign drop        = capture && full && !pop;
  assign timeout_hit = (cycle_count == TO_LAST);

  // Head outputs are gated by log_valid so they read zero when empty,
  // which also covers reset since count clears asynchronously.
  assign log_we   = log_valid & mem_we[rd_ptr];
  assign log_addr = log_valid ? mem_addr[rd_ptr] : '0;
  assign log_data = log_valid ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      halted      <= 1'b0;
      halt_cause  <= 2'd0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
          // Halt address has priority over the timeout on the same edge.
          if (is_halt) begin
            state      <= HALTED;
            halted     <= 1'b1;
            halt_cause <= 2'd1;
          end else if (timeout_hit) begin
            state      <= HALTED;
            halted     <= 1'b1;
            halt_cause <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_we[wr_ptr]   <= we;
      mem_addr[wr_ptr] <= address;
      mem_data[wr_ptr] <= we ? wdata : rdata;
    end
  end

endmodule

// File: doc/mem_access_monitor.md
MEM_ACCESS_MONITOR -- requirements
Module: mem_access_monitor

Interface
REQ-001 Parameters SHALL be: AW, 32, address width; DW, 32, data width; DEPTH, 16, log FIFO entries (power of 2, >=2); HALT_ADDR, 'hFFC, stop address; WIN_MASK, 'h800, window mask; WIN_MATCH, 'h800, window match value; TIMEOUT, 2000, run-cycle limit (>=1).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  level; leaving IDLE requires enable=1.
REQ-005 address  input  AW  bus address driven by the core.
REQ-006 we  input  1  bus write strobe.
REQ-007 wdata  input  DW  core write data.
REQ-008 rdata  input  DW  memory read data.
REQ-009 log_ready  input  1  consumer accepts the head entry.
REQ-010 log_valid  output  1  FIFO not empty.
REQ-011 log_we  output  1  head entry type: 1 = write, 0 = read.
REQ-012 log_addr  output  AW  head entry address.
REQ-013 log_data  output  DW  head entry data.
REQ-014 overflow  output  1  sticky: at least one capture was dropped.
REQ-015 drop_count  output  16  saturating count of dropped captures.
REQ-016 halted  output  1  state == HALTED.
REQ-017 halt_cause  output  2  0 = none, 1 = halt address, 2 = timeout.
REQ-018 cycle_count  output  32  cycles spent in RUN, saturating at all-ones.

Function
REQ-019 FSM SHALL have states IDLE, RUN, HALTED; IDLE->RUN on the first edge with enable=1; RUN->HALTED per REQ-020/021; HALTED is absorbing until reset; enable=0 in RUN SHALL NOT leave RUN.
REQ-020 In RUN, address==HALT_ADDR at an edge SHALL move to HALTED with halt_cause=1; that cycle SHALL NOT be captured.
REQ-021 In RUN, a halt address or cycle_count==TIMEOUT-1 at an edge SHALL move to HALTED, with cause 1 for the halt address and cause 2 for the timeout; when both hold together, cause 1 wins.
REQ-022 cycle_count SHALL increment by 1 on each RUN edge and hold in IDLE and HALTED.
REQ-023 Capture SHALL occur on a RUN edge when (address & WIN_MASK)==WIN_MATCH and address!=HALT_ADDR; one entry per qualifying cycle, including repeats of the same address.
REQ-024 An entry SHALL hold we, address, and data, where data = wdata if we=1, else rdata, sampled at that edge.
REQ-025 A captured entry SHALL appear at the FIFO output no earlier than the next cycle, i.e. log_valid rises one cycle after the capture edge into an empty FIFO.
REQ-026 Pop SHALL occur when log_valid && log_ready at an edge; log_* outputs SHALL show the oldest entry, in FIFO order.
REQ-027 A capture into a full FIFO with no simultaneous pop SHALL be dropped: overflow SHALL be set and drop_count incremented, saturating at 16'hFFFF.
REQ-028 A capture plus pop on a full FIFO SHALL accept both, leaving occupancy unchanged.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-030 The FIFO SHALL keep draining in HALTED and IDLE; log_ready while empty SHALL have no effect.
REQ-031 Capture SHALL occur only in RUN.

Reset
REQ-032 When resetn=0, the block SHALL immediately, independent of clk, enter IDLE and force log_valid=0, overflow=0, drop_count=0, halted=0, halt_cause=0, cycle_count=0, and empty the FIFO.
REQ-033 While resetn=0, log_we, log_addr, and log_data SHALL read 0.
REQ-034 Reset asserted mid-RUN or mid-drain SHALL discard all entries; after release the block SHALL wait in IDLE for enable.

Verification
REQ-035 Apply reset, enable=1, then write 0x800<-0x12345678 and read 0x804 with rdata=0xCAFE -> two entries in order, (1, 0x800, 0x12345678) then (0, 0x804, 0xCAFE); log_valid rises one cycle after the first capture.
REQ-036 Drive address 0x100 for 10 cycles, then 0xFFC -> no entries; halted=1 and halt_cause=1 on the next cycle; later 0x800 accesses are not captured.
REQ-037 With TIMEOUT=5, drive non-window addresses -> halted=1 with halt_cause=2 after 5 RUN cycles, cycle_count=5; 0xFFC on the limit cycle gives halt_cause=1.
REQ-038 With DEPTH=4, log_ready=0, and 6 window writes -> 4 entries kept (the oldest four), overflow=1, drop_count=2; then log_ready=1 -> 4 pops in order, then log_valid=0.
REQ-039 With DEPTH=4 full, a capture and a pop on the same edge -> occupancy stays 4, drop_count unchanged, and the new entry is last out.
REQ-040 Assert resetn=0 asynchronously mid-RUN with 3 entries queued -> all outputs zero before the next clk edge; after release with enable=0 the block stays in IDLE and window accesses are not captured.
